// File: rtl/regfile_pkg.sv
// Shared types and sizes for the register-file write-back scheduler.
package regfile_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 2 ** ADDR_W;

    typedef enum logic {
        INIT,
        RUN
    } state_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Write-back request bundle for the two requesters (ALU path and load/multi-cycle unit).
interface regfile_wb_arbiter_if #(
    parameter int DATA_W = regfile_pkg::DATA_W,
    parameter int ADDR_W = regfile_pkg::ADDR_W
);
    logic              req0_valid;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_data;
    logic              req0_ready;

    logic              req1_valid;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_data;
    logic              req1_ready;

    modport master (
        output req0_valid, req0_addr, req0_data,
        input  req0_ready,
        output req1_valid, req1_addr, req1_data,
        input  req1_ready
    );

    modport slave (
        input  req0_valid, req0_addr, req0_data,
        output req0_ready,
        input  req1_valid, req1_addr, req1_data,
        output req1_ready
    );
endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: a lone requester wins, a tie goes to the requester named by ptr.
module rr_arbiter2 (
    input  logic [1:0] valid,
    input  logic       ptr,
    output logic [1:0] grant,
    output logic       any
);
    for (genvar gi = 0; gi < 2; gi++) begin : g_grant
        assign grant[gi] = valid[gi] && (!valid[1-gi] || (ptr == 1'(gi)));
    end

    assign any = |valid;
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Drives the register file's single write port: zeroes x1..x31 after reset, then
// round-robins write-backs from the ALU and load/multi-cycle requesters.
module regfile_wb_arbiter #(
    parameter int DATA_W = regfile_pkg::DATA_W,
    parameter int ADDR_W = regfile_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    regfile_wb_arbiter_if.slave req,
    output logic              WE3,
    output logic [ADDR_W-1:0] A3,
    output logic [DATA_W-1:0] WD3,
    output logic              init_busy
);
    import regfile_pkg::*;

    localparam logic [ADDR_W-1:0] LAST_REG = {ADDR_W{1'b1}};

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] cnt_reg, cnt_next;
    logic              ptr_reg, ptr_next;
    logic              we3_reg, we3_next;
    logic [ADDR_W-1:0] a3_reg, a3_next;
    logic [DATA_W-1:0] wd3_reg, wd3_next;

    logic [1:0]        valid;
    logic [1:0]        grant;
    logic              any;
    logic              run;
    logic              xfer;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    assign valid = {req.req1_valid, req.req0_valid};

    rr_arbiter2 u_arb (
        .valid (valid),
        .ptr   (ptr_reg),
        .grant (grant),
        .any   (any)
    );

    // rst gates the handshake combinationally so nothing is accepted in the reset cycle.
    assign run            = (state_reg == RUN) && !rst;
    assign req.req0_ready = run && grant[0];
    assign req.req1_ready = run && grant[1];
    assign init_busy      = !run;
    assign xfer           = run && any;

    assign sel_addr = grant[1] ? req.req1_addr : req.req0_addr;
    assign sel_data = grant[1] ? req.req1_data : req.req0_data;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        ptr_next   = ptr_reg;
        we3_next   = 1'b0;
        a3_next    = a3_reg;
        wd3_next   = wd3_reg;
        case (state_reg)
            INIT: begin
                we3_next = 1'b1;
                a3_next  = cnt_reg;
                wd3_next = '0;
                cnt_next = cnt_reg + 1'b1;
                if (cnt_reg == LAST_REG) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (xfer) begin
                    // Pointer moves to whoever lost, even for a discarded x0 write.
                    ptr_next = grant[0];
                    if (sel_addr != '0) begin
                        we3_next = 1'b1;
                        a3_next  = sel_addr;
                        wd3_next = sel_data;
                    end
                end
            end
            default: state_next = INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= INIT;
            cnt_reg   <= {{(ADDR_W-1){1'b0}}, 1'b1};
            ptr_reg   <= 1'b0;
            we3_reg   <= 1'b0;
            a3_reg    <= '0;
            wd3_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            ptr_reg   <= ptr_next;
            we3_reg   <= we3_next;
            a3_reg    <= a3_next;
            wd3_reg   <= wd3_next;
        end
    end

    assign WE3 = we3_reg;
    assign A3  = a3_reg;
    assign WD3 = wd3_reg;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench: every accepted write and every sweep step is queued, and the
// write port is compared against the queue whenever WE3 is high.
module tb_regfile_wb_arbiter;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        we3;
    logic [4:0]  a3;
    logic [31:0] wd3;
    logic        init_busy;

    int  n_checks = 0;
    int  n_errors = 0;
    wr_t sb[$];
    logic ptr_m;

    regfile_wb_arbiter_if bus ();

    regfile_wb_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req       (bus.slave),
        .WE3       (we3),
        .A3        (a3),
        .WD3       (wd3),
        .init_busy (init_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_wr(input logic [4:0] addr, input logic [31:0] data);
        wr_t w;
        w.addr = addr;
        w.data = data;
        sb.push_back(w);
    endtask

    // Monitor: compare each register-file write against the oldest expected write.
    always @(negedge clk) begin
        if (we3 === 1'b1) begin
            if (sb.size() == 0) begin
                check_eq("unexpected_we3_addr", {59'd0, a3}, 64'hFFFF);
            end else begin
                wr_t w;
                w = sb.pop_front();
                check_eq("wr_addr", {59'd0, a3}, {59'd0, w.addr});
                check_eq("wr_data", {32'd0, wd3}, {32'd0, w.data});
                $display("write x%0d <= 0x%08h", a3, wd3);
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic set_idle();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.req0_addr  = '0;
        bus.req1_addr  = '0;
        bus.req0_data  = '0;
        bus.req1_data  = '0;
    endtask

    // Drive one RUN cycle, check readys against the bench's own grant model, queue the write.
    task automatic drive(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                         input logic v1, input logic [4:0] a1, input logic [31:0] d1);
        logic g;
        bus.req0_valid = v0; bus.req0_addr = a0; bus.req0_data = d0;
        bus.req1_valid = v1; bus.req1_addr = a1; bus.req1_data = d1;
        #1;
        if (v0 && v1) g = ptr_m;
        else          g = v1;
        check_eq("req0_ready", {63'd0, bus.req0_ready}, {63'd0, (v0 || v1) && !g});
        check_eq("req1_ready", {63'd0, bus.req1_ready}, {63'd0, (v0 || v1) && g});
        if (v0 || v1) begin
            if (!g && a0 != 5'd0) push_wr(a0, d0);
            if (g && a1 != 5'd0)  push_wr(a1, d1);
            $display("grant req%0d addr=%0d data=0x%08h", g, g ? a1 : a0, g ? d1 : d0);
            ptr_m = !g;
        end
    endtask

    // Called with rst still high at a step point; releases reset and walks the full sweep.
    task automatic sweep();
        rst = 1'b0;
        ptr_m = 1'b0;
        for (int i = 1; i <= 31; i++) push_wr(5'(i), 32'd0);
        bus.req0_valid = 1'b1; bus.req0_addr = 5'd4;
        bus.req1_valid = 1'b1; bus.req1_addr = 5'd6;
        for (int i = 1; i <= 30; i++) begin
            step();
            check_eq("init_busy_sweep", {63'd0, init_busy}, 64'd1);
            check_eq("req0_ready_init", {63'd0, bus.req0_ready}, 64'd0);
            check_eq("req1_ready_init", {63'd0, bus.req1_ready}, 64'd0);
        end
        set_idle();
        step();
        check_eq("init_busy_done", {63'd0, init_busy}, 64'd0);
        check_eq("sweep_drained", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        ptr_m = 1'b0;
        set_idle();
        bus.req0_valid = 1'b1;
        repeat (3) step();
        check_eq("rst_we3", {63'd0, we3}, 64'd0);
        check_eq("rst_a3", {59'd0, a3}, 64'd0);
        check_eq("rst_wd3", {32'd0, wd3}, 64'd0);
        check_eq("rst_init_busy", {63'd0, init_busy}, 64'd1);
        check_eq("rst_req0_ready", {63'd0, bus.req0_ready}, 64'd0);

        sweep();

        // Single ALU write.
        drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
        check_eq("solo_req0_ready", {63'd0, bus.req0_ready}, 64'd1);
        step();
        check_eq("solo_we3", {63'd0, we3}, 64'd1);
        check_eq("solo_a3", {59'd0, a3}, 64'd5);

        // x0 write: accepted, not performed, pointer moves back to 0.
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h1234);
        check_eq("x0_req1_ready", {63'd0, bus.req1_ready}, 64'd1);
        step();
        check_eq("x0_we3", {63'd0, we3}, 64'd0);

        // Continuous dual request alternates starting with req0.
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 5'd3, 32'hA0000000 + 32'(k), 1'b1, 5'd7, 32'hB0000000 + 32'(k));
            check_eq("alt_req0_ready", {63'd0, bus.req0_ready}, {63'd0, (k % 2) == 0});
            step();
        end

        // Write x9, then idle: WE3 low, A3 holds, ptr holds.
        drive(1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'd0);
        step();
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
            step();
            check_eq("idle_we3", {63'd0, we3}, 64'd0);
            check_eq("idle_a3", {59'd0, a3}, 64'd9);
        end
        drive(1'b1, 5'd10, 32'h10, 1'b1, 5'd11, 32'h11);
        check_eq("ptr_held_req1", {63'd0, bus.req1_ready}, 64'd1);
        step();

        // Random traffic.
        for (int k = 0; k < 60; k++) begin
            drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom(),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom());
            step();
        end
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        step();
        check_eq("traffic_drained", 64'(sb.size()), 64'd0);

        // Reset mid-sweep at A3=12; the sweep must restart from x1.
        rst = 1'b1;
        step();
        step();
        sb.delete();
        rst = 1'b0;
        for (int i = 1; i <= 31; i++) push_wr(5'(i), 32'd0);
        for (int i = 0; i < 40 && !(we3 === 1'b1 && a3 == 5'd12); i++) step();
        check_eq("reach_a3_12", {59'd0, a3}, 64'd12);
        rst = 1'b1;
        sb.delete();
        step();
        check_eq("midrst_we3", {63'd0, we3}, 64'd0);
        check_eq("midrst_a3", {59'd0, a3}, 64'd0);
        check_eq("midrst_busy", {63'd0, init_busy}, 64'd1);
        sweep();

        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd17, 32'hCAFEF00D);
        step();
        check_eq("post_sweep_we3", {63'd0, we3}, 64'd1);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        step();
        check_eq("final_drained", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
